// File: rtl/full_adder.sv
// Registered ripple-carry adder slice for the ALU datapath.
// Sum/c_out/out_valid are registered; WIDTH one-bit cells ripple the carry.

// One-bit combinational full-adder cell.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module full_adder #(
    parameter int WIDTH = 1
) (
    output logic             c_out,
    output logic [WIDTH-1:0] Sum,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             out_valid
);
    // c[i] is the carry into bit i; c[WIDTH] leaves the slice.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = c_in;

    // Ripple chain: each cell feeds its carry to the next, no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a     (A[i]),
            .b     (B[i]),
            .c_in  (c[i]),
            .s     (s[i]),
            .c_out (c[i+1])
        );
    end

    // Capture the result when operands are valid; otherwise hold and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Sum       <= s;
            c_out     <= c[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH = 1, 8 and 16.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // WIDTH=1 instance
    logic       a1, b1, ci1, iv1, co1, ov1;
    logic [0:0] s1;
    full_adder #(.WIDTH(1)) u_w1 (
        .c_out(co1), .Sum(s1), .A(a1), .B(b1), .c_in(ci1),
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .out_valid(ov1)
    );

    // WIDTH=8 instance
    logic [7:0] a8, b8, s8;
    logic       ci8, iv8, co8, ov8;
    full_adder #(.WIDTH(8)) u_w8 (
        .c_out(co8), .Sum(s8), .A(a8), .B(b8), .c_in(ci8),
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .out_valid(ov8)
    );

    // WIDTH=16 instance
    logic [15:0] a16, b16, s16;
    logic        ci16, iv16, co16, ov16;
    full_adder #(.WIDTH(16)) u_w16 (
        .c_out(co16), .Sum(s16), .A(a16), .B(b16), .c_in(ci16),
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .out_valid(ov16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       co;
        logic [7:0] s;
    } vec_t;

    vec_t tt1 [8];
    vec_t tt8 [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [16:0] exp17;
        logic [8:0]  exp9;

        // Hand-computed vectors {a, b, ci, co, s}
        tt1[0] = '{8'd0, 8'd0, 1'b0, 1'b0, 8'd0};
        tt1[1] = '{8'd0, 8'd0, 1'b1, 1'b0, 8'd1};
        tt1[2] = '{8'd0, 8'd1, 1'b0, 1'b0, 8'd1};
        tt1[3] = '{8'd0, 8'd1, 1'b1, 1'b1, 8'd0};
        tt1[4] = '{8'd1, 8'd0, 1'b0, 1'b0, 8'd1};
        tt1[5] = '{8'd1, 8'd0, 1'b1, 1'b1, 8'd0};
        tt1[6] = '{8'd1, 8'd1, 1'b0, 1'b1, 8'd0};
        tt1[7] = '{8'd1, 8'd1, 1'b1, 1'b1, 8'd1};
        tt8[0] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};
        tt8[1] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF};
        tt8[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80};
        tt8[3] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46};

        // Reset held with live operands: outputs must stay cleared
        a1 = 1; b1 = 1; ci1 = 1; iv1 = 1;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1; iv8 = 1;
        a16 = 16'hFFFF; b16 = 16'h1; ci16 = 1; iv16 = 1;
        step(); step();
        check("rst_w1_sum", 64'(s1), 64'd0);
        check("rst_w1_cout", 64'(co1), 64'd0);
        check("rst_w1_ov", 64'(ov1), 64'd0);
        check("rst_w8_sum", 64'(s8), 64'd0);
        check("rst_w16_sum", 64'(s16), 64'd0);
        rst_n = 1'b1;
        step();
        check("rel_w1_sum", 64'(s1), 64'd1);
        check("rel_w1_cout", 64'(co1), 64'd1);
        check("rel_w1_ov", 64'(ov1), 64'd1);

        // WIDTH=1 truth table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            a1 = tt1[i].a[0]; b1 = tt1[i].b[0]; ci1 = tt1[i].ci;
            step();
            check($sformatf("tt1_%0d_sum", i), 64'(s1), 64'(tt1[i].s[0]));
            check($sformatf("tt1_%0d_cout", i), 64'(co1), 64'(tt1[i].co));
            check($sformatf("tt1_%0d_ov", i), 64'(ov1), 64'd1);
        end

        // WIDTH=8 wrap-around vectors, last one feeds the hold test
        for (int i = 0; i < 4; i++) begin
            a8 = tt8[i].a; b8 = tt8[i].b; ci8 = tt8[i].ci;
            step();
            check($sformatf("tt8_%0d_sum", i), 64'(s8), 64'(tt8[i].s));
            check($sformatf("tt8_%0d_cout", i), 64'(co8), 64'(tt8[i].co));
            check($sformatf("tt8_%0d_ov", i), 64'(ov8), 64'd1);
        end

        // Hold: in_valid low, operand changes must not reach the outputs
        iv8 = 0; a8 = 8'hAA;
        step();
        check("hold_sum", 64'(s8), 64'h46);
        check("hold_cout", 64'(co8), 64'd0);
        check("hold_ov", 64'(ov8), 64'd0);
        step();
        check("hold2_sum", 64'(s8), 64'h46);
        iv8 = 1;

        // Mid-stream asynchronous reset on random WIDTH=8 traffic
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
                exp9 = 9'(a8) + 9'(b8) + 9'(ci8);
                step();
                check("strm_pre", 64'({co8, s8}), 64'(exp9));
            end
            #2 rst_n = 1'b0;
            #1;
            check("arst_sum", 64'(s8), 64'd0);
            check("arst_cout", 64'(co8), 64'd0);
            check("arst_ov", 64'(ov8), 64'd0);
            #1 rst_n = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            exp9 = 9'(a8) + 9'(b8) + 9'(ci8);
            step();
            check("strm_post", 64'({co8, s8}), 64'(exp9));
            check("strm_post_ov", 64'(ov8), 64'd1);
        end

        // 1000 random WIDTH=16 vectors against a + b + ci
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
            exp17 = 17'(a16) + 17'(b16) + 17'(ci16);
            step();
            check("rnd16", 64'({co16, s16}), 64'(exp17));
            check("rnd16_ov", 64'(ov16), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/full_adder.md
# full_adder

Registered full-adder slice for the ALU datapath. It adds two WIDTH-bit operands plus a carry-in and registers the sum and carry-out on the clock edge. Several slices can be chained through c_in/c_out, and multi-bit adders are built from one-bit cell instances. WIDTH=1 gives the classic one-bit full adder used by the ALU adder chain.

## Interface
- WIDTH, default 1: operand width in bits; legal range 1 to 64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- c_out  output  1  registered carry-out of the WIDTH-bit addition.
- Sum  output  WIDTH  registered sum bits, modulo 2^WIDTH.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- c_in  input  1  carry-in into bit 0.
- in_valid  input  1  operands are valid this cycle; when low, the outputs hold their values.
- out_valid  output  1  Sum/c_out hold a freshly computed result.
- Positional port order is c_out, Sum, A, B, c_in, clk, rst_n, in_valid, out_valid. Existing positional instantiations therefore keep binding the arithmetic ports.

## Operation
- Cell equations for bit i: s[i] = a[i] ^ b[i] ^ c[i], and c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - c[0] = c_in.
  - The carry out of the adder is c[WIDTH].
- The cell is a separate one-bit combinational submodule. The WIDTH-bit path is a generate loop that ripples carries through WIDTH instances. No carry-lookahead.
- The result is exact: {c_out, Sum} = A + B + c_in, as a (WIDTH+1)-bit unsigned value.
- Behaviour on each rising clk edge with rst_n high:
  - If in_valid = 1: Sum <= s, c_out <= c[WIDTH], out_valid <= 1.
  - If in_valid = 0: Sum and c_out hold, out_valid <= 0.
- The operands are treated as unsigned. Signed overflow is not reported.
- Wrap-around:
  - All-ones + all-ones + 1 gives Sum = all-ones, c_out = 1.
  - All-ones + 0 + 1 gives Sum = 0, c_out = 1.

## Timing
- Latency is one clock. The result of the operands sampled at edge n is visible on Sum/c_out/out_valid right after edge n.
- Throughput is one operation per clock. There is no back-pressure.
- Reset values: Sum = 0, c_out = 0, out_valid = 0.
- Reset is asynchronous. Asserting rst_n low clears all outputs immediately, independent of clk, including in the middle of a stream of valid operations.
- Release of rst_n is sampled synchronously. The first capture happens on the first rising edge where rst_n is high.
- Combinational path: the ripple from A/B/c_in to the output register D-input spans WIDTH cell delays. There is no combinational path from the inputs to the outputs.
- If in_valid and rst_n change at the same time as an edge, reset wins.

## Test plan
- Reset: hold rst_n = 0 with A = B = c_in = 1 and in_valid = 1 -> Sum = 0, c_out = 0, out_valid = 0. Release reset -> after the next edge, c_out = 1, Sum = 1.
- WIDTH=1 exhaustive truth table, applied one vector per cycle with in_valid = 1. Each response (c_out, Sum) appears one cycle after the vector:
  - A B c_in = 000 -> 0 0; 001 -> 0 1; 010 -> 0 1; 011 -> 1 0.
  - A B c_in = 100 -> 0 1; 101 -> 1 0; 110 -> 1 0; 111 -> 1 1.
- WIDTH=8 wrap-around:
  - 0xFF + 0x00 + 1 -> Sum = 0x00, c_out = 1.
  - 0xFF + 0xFF + 1 -> Sum = 0xFF, c_out = 1.
  - 0x7F + 0x01 + 0 -> Sum = 0x80, c_out = 0.
- Hold: compute 0x12 + 0x34 + 0 at WIDTH=8 -> Sum = 0x46. Then set in_valid = 0 and change A to 0xAA -> Sum stays 0x46, c_out stays 0, out_valid drops to 0.
- Asynchronous reset mid-stream: stream random WIDTH=8 vectors and assert rst_n between edges -> outputs are 0 before the next edge. After release, the outputs match a reference model computing A + B + c_in.
- Random compare: run 1000 random vectors at WIDTH=16 -> {c_out, Sum} equals A + B + c_in, delayed by one cycle, on every cycle.
